// File: rtl/mprj_div_pkg.sv
// Shared types and constants for the serial divider and its firmware smoke test.
package mprj_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Status codes posted on mprj_io[31:16]; firmware headers use the same values.
  localparam logic [15:0] SMOKE_START = 16'hAB60;
  localparam logic [15:0] SMOKE_PASS  = 16'hAB61;

endpackage

// File: rtl/mprj_serial_divider_if.sv
// Request/response handshake bundle between the Wishbone register slave and the divider.
interface mprj_serial_divider_if #(
  parameter int WIDTH = mprj_div_pkg::DIV_WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             out_div_by_zero;
  logic             busy;

  modport slave (
    input  in_valid, in_dividend, in_divisor, in_signed, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero, busy
  );

  modport master (
    output in_valid, in_dividend, in_divisor, in_signed, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero, busy
  );
endinterface

// File: rtl/mprj_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract divisor.
module mprj_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  localparam int RW = WIDTH + 1;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_ext;
  logic             ge;

  // Keep the difference when it is non-negative, otherwise restore the shifted value.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    dvs_ext = {2'b00, dvs_i};
    ge      = (shifted >= dvs_ext);
    rem_o   = ge ? RW'(shifted - dvs_ext) : RW'(shifted);
    quo_o   = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/mprj_serial_divider.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, one operation at a time.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | WIDTH shift/subtract iterations on operand magnitudes
// DONE  | result held on the outputs until out_ready
module mprj_serial_divider
  import mprj_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_ni,
  mprj_serial_divider_if.slave div
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             res_dbz_q, res_dbz_d;

  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

  mprj_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  assign div.in_ready        = (state_q == IDLE);
  assign div.out_valid       = (state_q == DONE);
  assign div.busy            = (state_q != IDLE);
  assign div.out_quotient    = res_quo_q;
  assign div.out_remainder   = res_rem_q;
  assign div.out_div_by_zero = res_dbz_q;

  // Operand magnitudes; unsigned mode treats the MSB as ordinary magnitude.
  always_comb begin
    dvd_neg = div.in_signed & div.in_dividend[WIDTH-1];
    dvs_neg = div.in_signed & div.in_divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~div.in_dividend + 1'b1) : div.in_dividend;
    dvs_mag = dvs_neg ? (~div.in_divisor + 1'b1) : div.in_divisor;
  end

  // Next-state and datapath update; special cases bypass CALC entirely.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    res_dbz_d = res_dbz_q;

    case (state_q)
      IDLE: begin
        if (div.in_valid) begin
          if (div.in_divisor == '0) begin
            state_d   = DONE;
            res_quo_d = '1;
            res_rem_d = div.in_dividend;
            res_dbz_d = 1'b1;
          end else if (div.in_signed && (div.in_dividend == MIN_VAL) &&
                       (div.in_divisor == '1)) begin
            state_d   = DONE;
            res_quo_d = MIN_VAL;
            res_rem_d = '0;
            res_dbz_d = 1'b0;
          end else begin
            state_d = CALC;
            rem_d   = '0;
            quo_d   = dvd_mag;
            dvs_d   = dvs_mag;
            cnt_d   = CNT_W'(WIDTH);
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = DONE;
          res_quo_d = q_neg_q ? (~quo_step + 1'b1) : quo_step;
          res_rem_d = r_neg_q ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
          res_dbz_d = 1'b0;
        end
      end
      DONE: begin
        if (div.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and result registers; reset clears everything immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      res_dbz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      res_dbz_q <= res_dbz_d;
    end
  end

endmodule

// File: tb/tb_mprj_serial_divider.sv
// Directed and random checks of the serial divider against an arithmetic reference.
module tb_mprj_serial_divider;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  mprj_serial_divider_if #(.WIDTH(W)) dif ();

  mprj_serial_divider #(.WIDTH(W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .div       (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; lat is rising edges from acceptance to out_valid.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0; z = 1'b0; lat = 0;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
      end
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
      lat = W;
    end
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold, input bit pulse);
    logic [W-1:0] eq, er;
    logic         ez;
    int           elat, lat;
    ref_div(a, b, s, eq, er, ez, elat);
    @(negedge clk);
    chk("in_ready_idle", dif.in_ready, 1);
    dif.in_valid    = 1'b1;
    dif.in_dividend = a;
    dif.in_divisor  = b;
    dif.in_signed   = s;
    @(posedge clk);
    @(negedge clk);
    dif.in_valid    = 1'b0;
    dif.in_dividend = $urandom;
    dif.in_divisor  = $urandom;
    dif.in_signed   = $urandom_range(0, 1);
    chk("busy_after_accept", dif.busy, 1);
    lat = 0;
    while (!dif.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency_edges", lat, elat);
    chk("quotient", dif.out_quotient, eq);
    chk("remainder", dif.out_remainder, er);
    chk("div_by_zero", dif.out_div_by_zero, ez);
    chk("in_ready_done", dif.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      dif.in_valid    = pulse && (i % 2 == 0);
      dif.in_dividend = $urandom;
      dif.in_divisor  = $urandom;
      @(negedge clk);
      chk("hold_valid", dif.out_valid, 1);
      chk("hold_quotient", dif.out_quotient, eq);
      chk("hold_remainder", dif.out_remainder, er);
      chk("hold_in_ready", dif.in_ready, 0);
      chk("hold_busy", dif.busy, 1);
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("consumed_valid", dif.out_valid, 0);
    chk("consumed_in_ready", dif.in_ready, 1);
    chk("kept_quotient", dif.out_quotient, eq);
    dif.out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    rst_n           = 1'b0;
    dif.in_valid    = 1'b0;
    dif.in_dividend = '0;
    dif.in_divisor  = '0;
    dif.in_signed   = 1'b0;
    dif.out_ready   = 1'b0;
    #22;
    chk("rst_in_ready", dif.in_ready, 1);
    chk("rst_out_valid", dif.out_valid, 0);
    chk("rst_busy", dif.busy, 0);
    chk("rst_quotient", dif.out_quotient, 0);
    chk("rst_remainder", dif.out_remainder, 0);
    chk("rst_dbz", dif.out_div_by_zero, 0);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 0, 1'b0);
    run_op(-32'sd100, 32'd7, 1'b1, 0, 1'b0);
    run_op(32'd100, -32'sd7, 1'b1, 0, 1'b0);
    run_op(32'd5, 32'd0, 1'b0, 0, 1'b0);
    run_op(32'd5, 32'd0, 1'b1, 0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0);
    run_op(32'h8000_0000, 32'd1, 1'b1, 0, 1'b0);
    run_op(32'd3, 32'd10, 1'b1, 0, 1'b0);
    run_op(32'd1234567, 32'd89, 1'b0, 10, 1'b1);
    run_op(-32'sd77, -32'sd5, 1'b1, 3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(1, 15);
        1:       rb = 32'(-$urandom_range(1, 1000));
        2:       rb = (i % 6 == 0) ? 32'd0 : $urandom;
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
    end

    // Reset in the middle of a calculation.
    @(negedge clk);
    dif.in_valid    = 1'b1;
    dif.in_dividend = 32'd1000;
    dif.in_divisor  = 32'd3;
    dif.in_signed   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dif.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midcalc_rst_in_ready", dif.in_ready, 1);
    chk("midcalc_rst_out_valid", dif.out_valid, 0);
    chk("midcalc_rst_busy", dif.busy, 0);
    chk("midcalc_rst_quotient", dif.out_quotient, 0);
    chk("midcalc_rst_remainder", dif.out_remainder, 0);
    chk("midcalc_rst_dbz", dif.out_div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dif.out_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.out_valid) seen++;
    end
    chk("no_result_after_reset", seen, 0);
    chk("in_ready_after_reset", dif.in_ready, 1);
    dif.out_ready = 1'b0;

    run_op(32'd1000, 32'd3, 1'b0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
